// File: rtl/nios2_switch_irq_ctrl.sv
// -----------------------------------------------------------------------------
// nios2_switch_irq_ctrl
//
// Avalon-MM slave for the board switches. Each switch is synchronised, then
// debounced on a slow sample tick. Edges of the debounced level are captured
// in sticky bits, and a maskable, level-sensitive interrupt is raised towards
// the Nios II.
//
// Register map (word addresses):
//   0  data         read-only, debounced switch levels (never masked)
//   1  reserved     reads 0, writes ignored
//   2  irqmask      read/write, WIDTH bits
//   3  edgecapture  read, write-1-to-clear; a new edge beats a clear
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, only [WIDTH-1:0] used
//   readdata    registered read data, 1-cycle latency
//   in_port     raw asynchronous switch inputs
//   irq         level interrupt request
// -----------------------------------------------------------------------------
module nios2_switch_irq_ctrl #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STABLE_SAMPLES  = 3,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0]                     sync1;
    logic [WIDTH-1:0]                     sync2;
    logic [CNT_W-1:0]                     tick_cnt;
    logic                                 tick;
    logic [WIDTH-1:0][STABLE_SAMPLES-1:0] hist;
    logic [WIDTH-1:0][STABLE_SAMPLES-1:0] hist_nxt;
    logic [WIDTH-1:0]                     debounced;
    logic [WIDTH-1:0]                     debounced_nxt;
    logic [WIDTH-1:0]                     debounced_d;
    logic [WIDTH-1:0]                     edge_ev;
    logic [WIDTH-1:0]                     irqmask;
    logic [WIDTH-1:0]                     irqmask_nxt;
    logic [WIDTH-1:0]                     edgecapture;
    logic [WIDTH-1:0]                     edgecapture_nxt;
    logic [WIDTH-1:0]                     clear_bits;
    logic                                 wr_en;
    logic                                 rd_en;
    logic                                 unused_wdata;

    assign unused_wdata = ^writedata[31:WIDTH];

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect &  write_n;
    assign tick  = (tick_cnt == CNT_MAX);

    // Debounce: on each tick the synchronised level is shifted into the
    // history; a bit flips only once the whole history agrees on the new level.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        hist_nxt      = hist;
        debounced_nxt = debounced;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_nxt[i] = {hist[i][STABLE_SAMPLES-2:0], sync2[i]};
                if (&hist_nxt[i] && !debounced[i]) begin
                    debounced_nxt[i] = 1'b1;
                end else if (~|hist_nxt[i] && debounced[i]) begin
                    debounced_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        edge_ev = '0;
        case (EDGE_TYPE)
            0:       edge_ev = debounced & ~debounced_d;
            1:       edge_ev = ~debounced & debounced_d;
            default: edge_ev = debounced ^ debounced_d;
        endcase
    end

    // Register write decode. OR-ing edge_ev in last makes a same-cycle edge
    // override a write-1-to-clear of that bit.
    always_comb begin
        clear_bits      = '0;
        irqmask_nxt     = irqmask;
        if (wr_en && address == ADDR_EDGE) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_MASK) begin
            irqmask_nxt = writedata[WIDTH-1:0];
        end
        edgecapture_nxt = (edgecapture & ~clear_bits) | edge_ev;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    // NOTE: the sample histories are flops, not a RAM, so they reset with
    // everything else; a switch held during reset must re-qualify afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            tick_cnt    <= '0;
            hist        <= '0;
            debounced   <= '0;
            debounced_d <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            hist        <= hist_nxt;
            debounced   <= debounced_nxt;
            debounced_d <= debounced;
            irqmask     <= irqmask_nxt;
            edgecapture <= edgecapture_nxt;
            // Next-state values, so a clear or mask write drops irq on the
            // same edge that updates the register.
            irq         <= |(edgecapture_nxt & irqmask_nxt);
            if (rd_en) begin
                case (address)
                    ADDR_DATA: readdata <= 32'(debounced);
                    ADDR_MASK: readdata <= 32'(irqmask);
                    ADDR_EDGE: readdata <= 32'(edgecapture);
                    default:   readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nios2_switch_irq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nios2_switch_irq_ctrl. Three instances (EDGE_TYPE 0, 1, 2)
// share all inputs. A reference model inside the bench predicts readdata and
// irq of each instance every clock; the driver pushes those predictions into a
// scoreboard queue and a separate monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_nios2_switch_irq_ctrl;

    localparam int W = 10;
    localparam int D = 4;
    localparam int S = 3;

    typedef struct packed {
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [W-1:0]     in_port;
    logic [2:0][31:0] readdata;
    logic [2:0]       irq;

    for (genvar t = 0; t < 3; t++) begin : g_dut
        nios2_switch_irq_ctrl #(
            .WIDTH(W), .DEBOUNCE_CYCLES(D), .STABLE_SAMPLES(S), .EDGE_TYPE(t)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .address(address),
            .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
            .readdata(readdata[t]), .in_port(in_port), .irq(irq[t])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus state
    bit           rst_drv;
    logic [W-1:0] sw;

    // Reference model state
    logic [W-1:0]      m_s1, m_s2, m_deb, m_deb_prev, m_mask;
    logic [2:0][W-1:0] m_ec;
    logic [2:0][31:0]  m_rd;
    logic [2:0]        m_irq;
    int                m_cyc;
    logic [W-1:0]      m_samples[$];

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int t, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge_type=%0d got=%h expected=%h at %0t", name, t, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int t, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ec[t]);
            default: return 32'd0;
        endcase
    endfunction

    // One clock of the specification's behaviour, using the inputs the DUT
    // samples at this edge.
    task automatic model_step();
        logic [W-1:0] new_deb, clr, mask_n, rise, fall;
        logic [2:0][W-1:0] ev;
        exp_t e;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; m_mask = '0;
            m_ec = '0; m_rd = '0; m_irq = '0; m_cyc = 0;
            m_samples = {};
            for (int k = 0; k < S; k++) m_samples.push_back('0);
        end else begin
            for (int t = 0; t < 3; t++)
                if (chipselect && write_n) m_rd[t] = model_read(t, address);
            new_deb = m_deb;
            if ((m_cyc % D) == D - 1) begin
                m_samples.push_back(m_s2);
                void'(m_samples.pop_front());
                for (int i = 0; i < W; i++) begin
                    int ones = 0;
                    foreach (m_samples[k]) ones += int'(m_samples[k][i]);
                    if (ones == S) new_deb[i] = 1'b1;
                    if (ones == 0) new_deb[i] = 1'b0;
                end
            end
            m_cyc++;
            rise  = m_deb & ~m_deb_prev;
            fall  = m_deb_prev & ~m_deb;
            ev[0] = rise;
            ev[1] = fall;
            ev[2] = rise | fall;
            clr    = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            mask_n = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : m_mask;
            for (int t = 0; t < 3; t++) begin
                m_ec[t]  = (m_ec[t] & ~clr) | ev[t];
                m_irq[t] = |(m_ec[t] & mask_n);
            end
            m_mask     = mask_n;
            m_deb_prev = m_deb;
            m_deb      = new_deb;
            m_s2       = m_s1;
            m_s1       = in_port;
        end
        e.rd  = m_rd;
        e.irq = m_irq;
        sb.push_back(e);
    endtask

    task automatic step(input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] wd);
        @(negedge clk);
        reset_n    = rst_drv;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        in_port    = sw;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b1, a, $urandom);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    // Monitor: compares every clock the driver has produced a prediction for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int t = 0; t < 3; t++) begin
                    check("readdata", t, readdata[t], e.rd[t]);
                    check("irq", t, 32'(irq[t]), 32'(e.irq[t]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; in_port = '0;
        rst_drv = 1'b0;
        sw = '0;

        // Reset with all switches on, release, then pulse reset mid-count.
        sw = 10'h3FF;
        idle(3);
        rst_drv = 1'b1;
        for (int k = 0; k < 6; k++) rd(2'(k));
        rst_drv = 1'b0;
        rd(2'd0); rd(2'd3);
        rst_drv = 1'b1;
        for (int k = 0; k < 16; k++) rd(2'd0);
        rd(2'd1); rd(2'd2); rd(2'd3);

        // Clean slate: switches off, captures cleared.
        sw = '0;
        idle(20);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);

        // Bouncing bit 0 never qualifies.
        for (int c = 0; c < 40; c++) begin
            sw[0] = ((c / 3) % 2) == 0;
            rd(2'd0);
        end
        sw[0] = 1'b0;
        for (int k = 0; k < 20; k++) rd(2'd0);
        rd(2'd3);

        // Edge + irq on bit 2, then W1C.
        wr(2'd2, 32'h004);
        sw[2] = 1'b1;
        for (int k = 0; k < 20; k++) rd(2'd3);
        wr(2'd3, 32'h004);
        idle(3);

        // Capture with mask off, then unmask.
        wr(2'd2, 32'h000);
        sw[5] = 1'b1;
        idle(20);
        rd(2'd3);
        wr(2'd2, 32'h020);
        idle(3);

        // W1C of bit 3 in the same clock as its edge event: set wins.
        wr(2'd3, 32'h3FF);
        wr(2'd2, 32'h008);
        sw[3] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (m_deb[3] && !m_deb_prev[3]) begin
                wr(2'd3, 32'h008);
                hit = 1'b1;
            end else begin
                idle(1);
            end
        end
        check("race_window_found", 0, 32'(hit), 32'd1);
        rd(2'd3);
        idle(2);

        // Press and release switch 7 with a clear between.
        wr(2'd3, 32'h3FF);
        sw[7] = 1'b1;
        idle(20);
        rd(2'd3);
        wr(2'd3, 32'h3FF);
        sw[7] = 1'b0;
        idle(20);
        rd(2'd3);
        wr(2'd2, 32'h3FF);
        idle(2);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (it == 200) begin
                rst_drv = 1'b0;
                idle($urandom_range(1, 3));
                rst_drv = 1'b1;
            end
            case (r)
                0, 1, 2: begin
                    sw[$urandom_range(0, W - 1)] ^= 1'b1;
                    idle($urandom_range(0, 15));
                end
                3: begin
                    int b;
                    b = $urandom_range(0, W - 1);
                    sw[b] ^= 1'b1;
                    idle($urandom_range(1, 3));
                    sw[b] ^= 1'b1;
                end
                4, 5: rd(2'($urandom_range(0, 3)));
                6:    wr(2'd2, $urandom);
                7:    wr(2'd3, $urandom);
                8:    wr(2'($urandom_range(0, 1)), $urandom);
                default: idle($urandom_range(1, 20));
            endcase
        end
        for (int a = 0; a < 4; a++) rd(2'(a));
        idle(3);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
